// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// InstrFetch (module instr_fetch)
// Fetch stage of the pipeline. It owns the fetch PC and issues in-order
// requests to instruction memory over a valid/grant handshake. Returned words
// go into a small buffer, and one instruction per cycle is handed to decode.
// A redirect from decode discards every word that is still in flight.
//
// Ports
//   i_aclk          clock
//   i_areset_n      asynchronous, active-low reset
//   i_branch_valid  redirect request from decode
//   i_branch_addr   redirect target (bits [1:0] are forced to zero)
//   i_stall         hazard unit: hold delivery this cycle
//   o_imem_req      instruction memory request valid
//   o_imem_addr     request address (current fetch PC)
//   i_imem_gnt      request accepted when o_imem_req & i_imem_gnt
//   i_imem_rvalid   response valid (responses return in request order)
//   i_imem_rdata    response instruction word
//   o_en            o_instruction/o_pc/o_pcplus4 valid for decode
//   o_instruction   instruction at the buffer head
//   o_pc            address of o_instruction
//   o_pcplus4       o_pc + 4
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned          INST_SIZE  = 32,
  parameter logic [INST_SIZE-1:0] RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_branch_valid,
  input  logic [INST_SIZE-1:0] i_branch_addr,
  input  logic                 i_stall,
  output logic                 o_imem_req,
  output logic [INST_SIZE-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic                 o_en,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic [INST_SIZE-1:0] o_pc,
  output logic [INST_SIZE-1:0] o_pcplus4
);

  // CW holds a buffer occupancy (0..FIFO_DEPTH). The in-flight and discard
  // counters get one extra bit: after a redirect, wrong-path requests still in
  // flight no longer hold credit, so the total in flight can briefly exceed
  // FIFO_DEPTH while fresh requests are issued behind them.
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned SW = OW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [INST_SIZE-1:0] RESET_PC_ALIGNED = RESET_PC & ~INST_SIZE'(3);

  logic [INST_SIZE-1:0] fetchPc_q, fetchPc_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [OW-1:0]        discard_q, discard_d;
  logic [CW-1:0]        fifoCount_q, fifoCount_d;
  logic [PW-1:0]        fifoRdPtr_q, fifoRdPtr_d;
  logic [PW-1:0]        fifoWrPtr_q, fifoWrPtr_d;
  logic [PW-1:0]        reqRdPtr_q, reqRdPtr_d;
  logic [PW-1:0]        reqWrPtr_q, reqWrPtr_d;

  logic [INST_SIZE-1:0] fifoInstr_q [FIFO_DEPTH];
  logic [INST_SIZE-1:0] fifoPc_q    [FIFO_DEPTH];
  logic [INST_SIZE-1:0] reqPc_q     [FIFO_DEPTH];

  logic [SW-1:0] liveCount;
  logic          creditOk;
  logic          issue;
  logic          respAccept;
  logic          respPush;
  logic          deliver;
  logic          headValid;

  // Circular pointer advance that also works for depths that are not a power of two.
  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Credit check and handshake qualifiers. Words that are already marked for
  // discard will never occupy the buffer, so they are removed from the live
  // count. The saturation term only keeps the in-flight counter from wrapping
  // if the memory sits on a long run of wrong-path responses.
  always_comb begin
    liveCount  = SW'(fifoCount_q) + SW'(outstanding_q) - SW'(discard_q);
    creditOk   = (liveCount < SW'(FIFO_DEPTH)) && (outstanding_q != '1);
    o_imem_req = i_areset_n & ~i_branch_valid & creditOk;
    issue      = o_imem_req & i_imem_gnt;
    respAccept = i_imem_rvalid & (outstanding_q != '0);
    respPush   = respAccept & ~i_branch_valid & (discard_q == '0);
    headValid  = (fifoCount_q != '0);
    deliver    = headValid & ~i_stall & ~i_branch_valid;
  end

  // Decode-facing outputs come straight from the buffer head and read as zero
  // whenever the buffer is empty, which covers the reset state.
  always_comb begin
    o_imem_addr   = fetchPc_q;
    o_en          = deliver;
    o_instruction = headValid ? fifoInstr_q[fifoRdPtr_q] : '0;
    o_pc          = headValid ? fifoPc_q[fifoRdPtr_q] : '0;
    o_pcplus4     = headValid ? fifoPc_q[fifoRdPtr_q] + INST_SIZE'(4) : '0;
  end

  // Next-state logic. A redirect overrides everything else: both queues are
  // emptied, and every request still in flight after this cycle's response
  // (if any) becomes wrong-path, so the discard count simply takes the new
  // in-flight count. That also keeps back-to-back redirects consistent.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(respAccept);
    discard_d     = discard_q;
    fifoCount_d   = fifoCount_q + CW'(respPush) - CW'(deliver);
    fifoWrPtr_d   = respPush ? ptrInc(fifoWrPtr_q) : fifoWrPtr_q;
    fifoRdPtr_d   = deliver  ? ptrInc(fifoRdPtr_q) : fifoRdPtr_q;
    reqWrPtr_d    = issue    ? ptrInc(reqWrPtr_q)  : reqWrPtr_q;
    reqRdPtr_d    = respPush ? ptrInc(reqRdPtr_q)  : reqRdPtr_q;
    if (issue) begin
      fetchPc_d = fetchPc_q + INST_SIZE'(4);
    end
    if (respAccept && (discard_q != '0)) begin
      discard_d = discard_q - OW'(1);
    end
    if (i_branch_valid) begin
      fetchPc_d   = i_branch_addr & ~INST_SIZE'(3);
      discard_d   = outstanding_d;
      fifoCount_d = '0;
      fifoWrPtr_d = '0;
      fifoRdPtr_d = '0;
      reqWrPtr_d  = '0;
      reqRdPtr_d  = '0;
    end
  end

  // Control state. Reset drops everything in flight, so late responses from
  // before the reset land on a zero in-flight count and are ignored.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      fetchPc_q     <= RESET_PC_ALIGNED;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifoCount_q   <= '0;
      fifoRdPtr_q   <= '0;
      fifoWrPtr_q   <= '0;
      reqRdPtr_q    <= '0;
      reqWrPtr_q    <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifoCount_q   <= fifoCount_d;
      fifoRdPtr_q   <= fifoRdPtr_d;
      fifoWrPtr_q   <= fifoWrPtr_d;
      reqRdPtr_q    <= reqRdPtr_d;
      reqWrPtr_q    <= reqWrPtr_d;
    end
  end

  // Storage arrays. Their contents only matter behind the valid pointers, so
  // they are not reset. The pc of each issued request is remembered and
  // paired with its word when that word comes back.
  always_ff @(posedge i_aclk) begin
    if (issue) begin
      reqPc_q[reqWrPtr_q] <= fetchPc_q;
    end
    if (respPush) begin
      fifoInstr_q[fifoWrPtr_q] <= i_imem_rdata;
      fifoPc_q[fifoWrPtr_q]    <= reqPc_q[reqRdPtr_q];
    end
  end

  // Protocol checks: no response without a request in flight, and live
  // occupancy never exceeds the buffer.
  assert property (@(posedge i_aclk) disable iff (!i_areset_n)
                   i_imem_rvalid |-> (outstanding_q != '0));
  assert property (@(posedge i_aclk) disable iff (!i_areset_n)
                   liveCount <= SW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// TbInstrFetch (module tb_instr_fetch)
// Directed bench for instr_fetch with default parameters. A small memory model
// answers granted requests in order. Each vector gives the controls for one
// cycle and the hand-computed outputs expected in that cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  localparam int W = 32;

  logic         i_aclk;
  logic         i_areset_n;
  logic         i_branch_valid;
  logic [W-1:0] i_branch_addr;
  logic         i_stall;
  logic         o_imem_req;
  logic [W-1:0] o_imem_addr;
  logic         i_imem_gnt;
  logic         i_imem_rvalid;
  logic [W-1:0] i_imem_rdata;
  logic         o_en;
  logic [W-1:0] o_instruction;
  logic [W-1:0] o_pc;
  logic [W-1:0] o_pcplus4;

  // ctl = {gnt, respEnable, stall, branch}; expHd = {expEn, checkHead}
  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] brAddr;
    logic         expReq;
    logic [W-1:0] expAddr;
    logic [1:0]   expHd;
    logic [W-1:0] expPc;
  } vecT;

  int           assertCount = 0;
  int           failCount   = 0;
  logic [W-1:0] memQ [$];
  vecT          tbl [$];

  instr_fetch dut (
    .i_aclk         (i_aclk),
    .i_areset_n     (i_areset_n),
    .i_branch_valid (i_branch_valid),
    .i_branch_addr  (i_branch_addr),
    .i_stall        (i_stall),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .o_en           (o_en),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc),
    .o_pcplus4      (o_pcplus4)
  );

  // Free-running clock, period 10.
  initial begin
    i_aclk = 1'b0;
    forever #5 i_aclk = ~i_aclk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory contents: each word is derived from its address.
  function automatic logic [W-1:0] memWord(input logic [W-1:0] addr);
    return addr ^ 32'hC0DE_5A00;
  endfunction

  function automatic vecT mk(input logic [3:0] ctl, input logic [W-1:0] brAddr,
                             input logic expReq, input logic [W-1:0] expAddr,
                             input logic [1:0] expHd, input logic [W-1:0] expPc);
    vecT v;
    v.ctl     = ctl;
    v.brAddr  = brAddr;
    v.expReq  = expReq;
    v.expAddr = expAddr;
    v.expHd   = expHd;
    v.expPc   = expPc;
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; the memory answers the oldest granted request.
  task automatic applyStimulus(input vecT v);
    i_imem_gnt     = v.ctl[3];
    i_stall        = v.ctl[1];
    i_branch_valid = v.ctl[0];
    i_branch_addr  = v.brAddr;
    if (v.ctl[2] && (memQ.size() > 0)) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = memWord(memQ.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
  endtask

  task automatic checkOutput(input vecT v, input string tag);
    compareVal({tag, " o_en"}, W'(o_en), W'(v.expHd[1]));
    compareVal({tag, " o_imem_req"}, W'(o_imem_req), W'(v.expReq));
    if (v.expReq) begin
      compareVal({tag, " o_imem_addr"}, o_imem_addr, v.expAddr);
    end
    if (v.expHd != 2'b00) begin
      compareVal({tag, " o_pc"}, o_pc, v.expPc);
      compareVal({tag, " o_instruction"}, o_instruction, memWord(v.expPc));
      if (v.expHd[1]) begin
        compareVal({tag, " o_pcplus4"}, o_pcplus4, v.expPc + 32'd4);
      end
    end
  endtask

  // One cycle: drive at posedge+1, check at the falling edge, log any grant.
  task automatic runVector(input vecT v, input string tag);
    applyStimulus(v);
    #4;
    checkOutput(v, tag);
    if (o_imem_req && i_imem_gnt) begin
      memQ.push_back(o_imem_addr);
    end
    @(posedge i_aclk);
    #1;
  endtask

  task automatic runList(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      runVector(tbl[i], $sformatf("%s[%0d]", tag, i));
    end
    tbl.delete();
  endtask

  // Asynchronous reset: outputs must clear at once, memory forgets in-flight work.
  task automatic resetDut(input string tag);
    i_areset_n     = 1'b0;
    i_branch_valid = 1'b0;
    i_branch_addr  = '0;
    i_stall        = 1'b0;
    i_imem_gnt     = 1'b0;
    i_imem_rvalid  = 1'b0;
    i_imem_rdata   = '0;
    memQ.delete();
    #1;
    compareVal({tag, " o_imem_req"}, W'(o_imem_req), '0);
    compareVal({tag, " o_en"}, W'(o_en), '0);
    compareVal({tag, " o_pc"}, o_pc, '0);
    compareVal({tag, " o_instruction"}, o_instruction, '0);
    compareVal({tag, " o_pcplus4"}, o_pcplus4, '0);
    repeat (2) @(posedge i_aclk);
    #1;
    i_areset_n = 1'b1;
  endtask

  initial begin
    i_areset_n = 1'b1;
    #2;
    resetDut("reset");

    // Streaming from reset, grant held off for five cycles, then a stall with a full buffer.
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h00, 2'b00, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h04, 2'b00, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b0, 32'h00, 2'b10, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h08, 2'b10, 32'h04));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h0C, 2'b00, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b0, 32'h00, 2'b10, 32'h08));
    tbl.push_back(mk(4'b0100, 32'h0, 1'b1, 32'h10, 2'b10, 32'h0C));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(4'b0100, 32'h0, 1'b1, 32'h10, 2'b00, 32'h00));
    end
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h10, 2'b00, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h14, 2'b00, 32'h00));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(4'b1110, 32'h0, 1'b0, 32'h00, 2'b01, 32'h10));
    end
    tbl.push_back(mk(4'b1100, 32'h0, 1'b0, 32'h00, 2'b10, 32'h10));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h18, 2'b10, 32'h14));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h1C, 2'b00, 32'h00));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b0, 32'h00, 2'b10, 32'h18));
    tbl.push_back(mk(4'b1100, 32'h0, 1'b1, 32'h20, 2'b10, 32'h1C));
    runList("stream");

    // Redirect with 0x8 and 0xC in flight to an unaligned target.
    resetDut("reset2");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h000, 2'b00, 32'h000), "redir0");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h004, 2'b00, 32'h000), "redir1");
    runVector(mk(4'b1100, 32'h0,   1'b0, 32'h000, 2'b10, 32'h000), "redir2");
    runVector(mk(4'b1000, 32'h0,   1'b1, 32'h008, 2'b10, 32'h004), "redir3");
    runVector(mk(4'b1000, 32'h0,   1'b1, 32'h00C, 2'b00, 32'h000), "redir4");
    runVector(mk(4'b1001, 32'h103, 1'b0, 32'h000, 2'b00, 32'h000), "redir5");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h100, 2'b00, 32'h000), "redir6");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h104, 2'b00, 32'h000), "redir7");
    runVector(mk(4'b1100, 32'h0,   1'b0, 32'h000, 2'b00, 32'h000), "redir8");
    runVector(mk(4'b1100, 32'h0,   1'b0, 32'h000, 2'b10, 32'h100), "redir9");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h108, 2'b10, 32'h104), "redir10");

    // Redirect in the same cycle as a live response, buffer at full credit.
    runVector(mk(4'b1110, 32'h0,   1'b1, 32'h10C, 2'b00, 32'h000), "sameCyc0");
    runVector(mk(4'b1101, 32'h200, 1'b0, 32'h000, 2'b01, 32'h108), "sameCyc1");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h200, 2'b00, 32'h000), "sameCyc2");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h204, 2'b00, 32'h000), "sameCyc3");
    runVector(mk(4'b1100, 32'h0,   1'b0, 32'h000, 2'b10, 32'h200), "sameCyc4");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h208, 2'b10, 32'h204), "sameCyc5");

    // Back-to-back redirects: the last target wins.
    runVector(mk(4'b1001, 32'h300, 1'b0, 32'h000, 2'b00, 32'h000), "b2b0");
    runVector(mk(4'b1101, 32'h405, 1'b0, 32'h000, 2'b00, 32'h000), "b2b1");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h404, 2'b00, 32'h000), "b2b2");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h408, 2'b00, 32'h000), "b2b3");
    runVector(mk(4'b1100, 32'h0,   1'b0, 32'h000, 2'b10, 32'h404), "b2b4");
    runVector(mk(4'b1100, 32'h0,   1'b1, 32'h40C, 2'b10, 32'h408), "b2b5");

    // Reset with two requests in flight, then restart from the reset PC.
    runVector(mk(4'b1000, 32'h0, 1'b1, 32'h410, 2'b00, 32'h000), "midRst0");
    resetDut("midRst");
    runVector(mk(4'b1100, 32'h0, 1'b1, 32'h000, 2'b00, 32'h000), "restart0");
    runVector(mk(4'b1100, 32'h0, 1'b1, 32'h004, 2'b00, 32'h000), "restart1");
    runVector(mk(4'b1100, 32'h0, 1'b0, 32'h000, 2'b10, 32'h000), "restart2");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
